// File: rtl/dt_walk_pkg.sv
// Shared types and constants for the decision-tree walk engine.
// The node layout below is the packed format carried on cfg_wdata.
package dt_walk_pkg;

    localparam int N         = 8;
    localparam int NF        = 13;
    localparam int C         = 1;
    localparam int NODES     = 64;
    localparam int MAX_STEPS = 16;

    localparam int FW = $clog2(NF);
    localparam int AW = $clog2(NODES);
    localparam int DW = $clog2(MAX_STEPS + 1);

    typedef struct packed {
        logic          is_leaf;
        logic [FW-1:0] feat_idx;
        logic [N-1:0]  thr;
        logic [AW-1:0] t_child;
        logic [AW-1:0] f_child;
        logic [C-1:0]  cls;
    } node_t;

    localparam int NODE_W = $bits(node_t);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_e;

    // An unprogrammed entry is a class-0 leaf.
    localparam node_t NODE_RESET = '{1'b1, '0, '0, '0, '0, '0};

endpackage

// File: rtl/dt_walk_engine_if.sv
// Config, feature-input and result handshakes of the walk engine.
// The engine takes the slave side; the feature source/consumer takes master.
interface dt_walk_engine_if;
    import dt_walk_pkg::*;

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [NODE_W-1:0] cfg_wdata;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [NF*N-1:0]   in_feat;
    logic              out_valid;
    logic              out_ready;
    logic [C-1:0]      out_cls;
    logic [DW-1:0]     out_depth;
    logic              out_err;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        output cfg_ready, in_ready, out_valid, out_cls, out_depth, out_err
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, in_feat, out_ready,
        input  cfg_ready, in_ready, out_valid, out_cls, out_depth, out_err
    );

endinterface

// File: rtl/dt_node_table.sv
// Node table: register array with one write port and one combinational read port.
// Every entry resets so the tree is cleared together with the engine.
module dt_node_table
    import dt_walk_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  node_t         wdata,
    input  logic [AW-1:0] raddr,
    output node_t         rdata
);

    node_t mem_q [NODES];
    node_t mem_d [NODES];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // NOTE: this array is flops, not RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) mem_q[i] <= NODE_RESET;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dt_walk_engine.sv
// Sequenced decision-tree classifier: walks one node per clock through a
// single shared feature<threshold comparator, table reloadable while idle.
module dt_walk_engine
    import dt_walk_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    dt_walk_engine_if.slave   bus
);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]   step_q, step_d;
    logic [NF*N-1:0] feat_q, feat_d;
    logic [C-1:0]    cls_q, cls_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            err_q, err_d;

    node_t      node;
    logic [N-1:0] feat_sel;
    logic       tbl_we;

    assign tbl_we = bus.cfg_we && (state_q == IDLE);

    dt_node_table u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (bus.cfg_addr),
        .wdata (node_t'(bus.cfg_wdata)),
        .raddr (ptr_q),
        .rdata (node)
    );

    // Mux by equality so an illegal feat_idx never indexes past the vector.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < NF; i++) begin
            if (node.feat_idx == FW'(i)) feat_sel = feat_q[i*N +: N];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            step_q  <= '0;
            feat_q  <= '0;
            cls_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            feat_q  <= feat_d;
            cls_q   <= cls_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of latches.
        state_d = state_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        feat_d  = feat_q;
        cls_d   = cls_q;
        depth_d = depth_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    feat_d  = bus.in_feat;
                    ptr_d   = '0;
                    step_d  = '0;
                    state_d = WALK;
                end
            end
            WALK: begin
                if (node.is_leaf) begin
                    cls_d   = node.cls;
                    depth_d = step_q;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (node.feat_idx >= FW'(NF) || step_q == DW'(MAX_STEPS)) begin
                    cls_d   = '0;
                    depth_d = step_q;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ptr_d  = (feat_sel < node.thr) ? node.t_child : node.f_child;
                    step_d = step_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.cfg_ready = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_cls   = cls_q;
        bus.out_depth = depth_q;
        bus.out_err   = err_q;
    end

endmodule

// File: tb/tb_dt_walk_engine.sv
// Self-checking bench for dt_walk_engine: directed tree cases plus random
// trees and vectors, compared against a software tree walk.
module tb_dt_walk_engine;
    import dt_walk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dt_walk_engine_if bus ();

    dt_walk_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    node_t m_tab [NODES];
    bit    exp_busy = 1'b0;
    bit    prev_v   = 1'b0;
    int    exp_cls, exp_depth, exp_err, exp_lat, acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic node_t mk(input int leaf, input int idx, input int thr,
                                 input int t, input int f, input int cls);
        node_t n;
        n.is_leaf  = leaf[0];
        n.feat_idx = FW'(idx);
        n.thr      = N'(thr);
        n.t_child  = AW'(t);
        n.f_child  = AW'(f);
        n.cls      = C'(cls);
        return n;
    endfunction

    function automatic logic [NF*N-1:0] rand_fv(input int f2);
        logic [NF*N-1:0] fv;
        for (int i = 0; i < NF; i++) fv[i*N +: N] = N'($urandom);
        if (f2 >= 0) fv[2*N +: N] = N'(f2);
        return fv;
    endfunction

    // Software walk of the model table: follow child pointers until a leaf,
    // an illegal feature index, or the step budget is exhausted.
    function automatic void model(input logic [NF*N-1:0] fv,
                                  output int cls, output int depth, output int err);
        int    ptr;
        node_t n;
        ptr = 0; cls = 0; depth = 0; err = 0;
        for (int step = 0; step <= MAX_STEPS; step++) begin
            n = m_tab[ptr];
            if (n.is_leaf) begin
                cls = int'(n.cls); depth = step; return;
            end
            if (int'(n.feat_idx) >= NF || step == MAX_STEPS) begin
                err = 1; depth = step; return;
            end
            ptr = (fv[int'(n.feat_idx)*N +: N] < n.thr) ? int'(n.t_child) : int'(n.f_child);
        end
    endfunction

    // Result compare: every negedge while a transaction is outstanding.
    always @(negedge clk) begin
        if (rst_n && exp_busy) begin
            check("busy_in_ready", bus.in_ready, 0);
            check("busy_cfg_ready", bus.cfg_ready, 0);
            if (bus.out_valid) begin
                if (!prev_v) check("latency", cyc - acc_cyc, exp_lat);
                check("out_cls", bus.out_cls, exp_cls);
                check("out_depth", bus.out_depth, exp_depth);
                check("out_err", bus.out_err, exp_err);
            end
            prev_v = bus.out_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < NODES; i++) m_tab[i] = NODE_RESET;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        exp_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic wr(input int addr, input node_t n);
        @(negedge clk);
        #1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = AW'(addr);
        bus.cfg_wdata = n;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        m_tab[addr] = n;
    endtask

    task automatic write_tree3();
        wr(0, mk(0, 2, 1, 1, 2, 0));
        wr(1, mk(1, 0, 0, 0, 0, 1));
        wr(2, mk(1, 0, 0, 0, 0, 0));
    endtask

    task automatic run_vec(input logic [NF*N-1:0] fv, input int hold,
                           input bit cfg_same, input int caddr, input node_t cnode,
                           input bit pin, input int pc, input int pd, input int pe,
                           input bit abort_done, input bit cfg_in_done);
        int to;
        int c, d, e;
        @(negedge clk);
        to = 0;
        while (!bus.in_ready && to < 40) begin
            @(negedge clk);
            to++;
        end
        if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 1);
        #1;
        bus.in_valid = 1'b1;
        bus.in_feat  = fv;
        if (cfg_same) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = AW'(caddr);
            bus.cfg_wdata = cnode;
            m_tab[caddr]  = cnode;
        end
        model(fv, c, d, e);
        if (pin) begin
            check("model_cls", c, pc);
            check("model_depth", d, pd);
            check("model_err", e, pe);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.in_feat  = rand_fv(-1);
        exp_cls = c; exp_depth = d; exp_err = e; exp_lat = d + 1;
        acc_cyc  = cyc;
        exp_busy = 1'b1;
        to = 0;
        do begin
            @(negedge clk);
            to++;
        end while (!bus.out_valid && to < 60);
        if (!bus.out_valid) begin
            check("out_valid_timeout", bus.out_valid, 1);
            reset_dut();
            return;
        end
        if (abort_done) begin
            #1 rst_n = 1'b0;
            #1 check("reset_done_valid", bus.out_valid, 0);
            check("reset_done_in_ready", bus.in_ready, 1);
            exp_busy = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            clear_model();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            #1;
            if (cfg_in_done && h == 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = '0;
                bus.cfg_wdata = mk(1, 0, 0, 0, 0, 1);
            end
            @(posedge clk);
            #1 bus.cfg_we = 1'b0;
            @(negedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        exp_busy = 1'b0;
        @(negedge clk);
        check("bubble_valid", bus.out_valid, 0);
        check("bubble_in_ready", bus.in_ready, 1);
        check("bubble_cfg_ready", bus.cfg_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        node_t nz;
        nz = NODE_RESET;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.in_valid = 1'b0; bus.in_feat = '0; bus.out_ready = 1'b0;
        clear_model();
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_cls", bus.out_cls, 0);
        check("rst_out_depth", bus.out_depth, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_in_ready", bus.in_ready, 1);
        reset_dut();

        // Unprogrammed table: class 0 at depth 0.
        run_vec(rand_fv(-1), 0, 0, 0, nz, 1, 0, 0, 0, 0, 0);

        write_tree3();
        run_vec(rand_fv(0),   0, 0, 0, nz, 1, 1, 1, 0, 0, 0);
        run_vec(rand_fv(1),   0, 0, 0, nz, 1, 0, 1, 0, 0, 0);
        run_vec(rand_fv(255), 0, 0, 0, nz, 1, 0, 1, 0, 0, 0);

        // Held result with an ignored config write, then prove node0 unchanged.
        run_vec(rand_fv(0), 5, 0, 0, nz, 1, 1, 1, 0, 0, 1);
        run_vec(rand_fv(7), 0, 0, 0, nz, 1, 0, 1, 0, 0, 0);

        // Write and accept in the same cycle: walk sees the new entry.
        run_vec(rand_fv(0), 0, 1, 0, mk(1, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0, 0);

        // Self-loop hits the step limit.
        wr(0, mk(0, 0, 128, 0, 0, 0));
        run_vec(rand_fv(-1), 1, 0, 0, nz, 1, 0, 16, 1, 0, 0);

        // Illegal feature index.
        wr(0, mk(0, 13, 9, 1, 2, 0));
        run_vec(rand_fv(-1), 0, 0, 0, nz, 1, 0, 0, 1, 0, 0);

        // Reset while DONE, then the table must be cleared.
        write_tree3();
        run_vec(rand_fv(0), 0, 0, 0, nz, 0, 0, 0, 0, 1, 0);
        run_vec(rand_fv(0), 0, 0, 0, nz, 1, 0, 0, 0, 0, 0);

        // Reset while WALK.
        write_tree3();
        @(negedge clk);
        #1 bus.in_valid = 1'b1; bus.in_feat = rand_fv(0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_walk_valid", bus.out_valid, 0);
        check("reset_walk_in_ready", bus.in_ready, 1);
        repeat (3) @(posedge clk);
        #1 check("reset_walk_still_idle", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        run_vec(rand_fv(0), 0, 0, 0, nz, 1, 0, 0, 0, 0, 0);

        // Random trees and vectors.
        for (int i = 0; i < 24; i++) begin
            wr(i, mk(($urandom_range(0, 9) < 3) ? 1 : 0,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 12),
                     $urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 1)));
        end
        for (int v = 0; v < 60; v++) begin
            bit cs;
            cs = ($urandom_range(0, 7) == 0);
            run_vec(rand_fv(-1), $urandom_range(0, 3), cs, $urandom_range(0, 31),
                    mk(($urandom_range(0, 9) < 3) ? 1 : 0, $urandom_range(0, 12),
                       $urandom_range(0, 255), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 1)),
                    0, 0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
